// File: rtl/passive_arm_ctrl.sv
// passive_arm_ctrl: arming delay, intrusion watch, entry grace and
// time-limited siren downstream of the passive-security decode.
module passive_arm_ctrl #(
    parameter int ARM_DELAY   = 16,
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 32,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       PassiveSignal,
    input  logic       OpenDoorSign,
    input  logic       IgnitionSignalOn,
    input  logic       DisarmKey,
    output logic       ArmingLed,
    output logic       Armed,
    output logic       Siren,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMING = 3'd1,
        S_ARMED  = 3'd2,
        S_ENTRY  = 3'd3,
        S_ALARM  = 3'd4
    } state_e;

    // Terminal counts: each timed state exits on the edge where cnt == delay-1
    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_TIME - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timed;

    // Next-state selection; disarm dominates every other condition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!DisarmKey && PassiveSignal)
                    state_d = S_ARMING;
            end
            S_ARMING: begin
                if (DisarmKey || !PassiveSignal)
                    state_d = S_IDLE;
                else if (cnt_q == ARM_LAST)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                if (DisarmKey)
                    state_d = S_IDLE;
                else if (IgnitionSignalOn)
                    state_d = S_ALARM;
                else if (OpenDoorSign)
                    state_d = S_ENTRY;
            end
            S_ENTRY: begin
                if (DisarmKey)
                    state_d = S_IDLE;
                else if (cnt_q == ENTRY_LAST)
                    state_d = S_ALARM;
            end
            S_ALARM: begin
                if (DisarmKey)
                    state_d = S_IDLE;
                else if (cnt_q == SIREN_LAST)
                    state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter only runs in timed states so untimed dwell can never wrap it
    always_comb begin
        timed = (state_q == S_ARMING) || (state_q == S_ENTRY) ||
                (state_q == S_ALARM);
        cnt_d = '0;
        if (state_d == state_q && timed)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State, counter and Moore outputs registered from the next state
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ArmingLed <= 1'b0;
            Armed     <= 1'b0;
            Siren     <= 1'b0;
            State     <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ArmingLed <= (state_d == S_ARMING);
            Armed     <= (state_d == S_ARMED) || (state_d == S_ENTRY) ||
                         (state_d == S_ALARM);
            Siren     <= (state_d == S_ALARM);
            State     <= state_d;
        end
    end

endmodule

// File: tb/tb_passive_arm_ctrl.sv
// tb_passive_arm_ctrl: directed scenarios plus randomized traffic against
// a deadline-based reference model, on a default and a minimum-delay DUT.
module tb_passive_arm_ctrl;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic PassiveSignal = 1'b0;
    logic OpenDoorSign = 1'b0;
    logic IgnitionSignalOn = 1'b0;
    logic DisarmKey = 1'b0;

    logic       led0, arm0, sir0;
    logic [2:0] st0;
    logic       led1, arm1, sir1;
    logic [2:0] st1;

    int tests_run = 0;
    int failed = 0;

    // model: 0 = default-parameter DUT, 1 = all-delays-one DUT
    int cyc = 0;
    int mst[2] = '{0, 0};
    int mdl[2] = '{0, 0};
    int AD[2] = '{16, 1};
    int ED[2] = '{8, 1};
    int ST[2] = '{32, 1};

    always #5 clk = ~clk;

    passive_arm_ctrl dut (
        .clk(clk), .reset_L(reset_L),
        .PassiveSignal(PassiveSignal), .OpenDoorSign(OpenDoorSign),
        .IgnitionSignalOn(IgnitionSignalOn), .DisarmKey(DisarmKey),
        .ArmingLed(led0), .Armed(arm0), .Siren(sir0), .State(st0)
    );

    passive_arm_ctrl #(
        .ARM_DELAY(1), .ENTRY_DELAY(1), .SIREN_TIME(1), .CNT_W(1)
    ) dutc (
        .clk(clk), .reset_L(reset_L),
        .PassiveSignal(PassiveSignal), .OpenDoorSign(OpenDoorSign),
        .IgnitionSignalOn(IgnitionSignalOn), .DisarmKey(DisarmKey),
        .ArmingLed(led1), .Armed(arm1), .Siren(sir1), .State(st1)
    );

    // Reference: each timed state ends at an absolute deadline edge
    task automatic model_edge(input bit ps, od, ig, dk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int ns;
            ns = mst[k];
            case (mst[k])
                0: if (!dk && ps) ns = 1;
                1: if (dk || !ps) ns = 0; else if (cyc == mdl[k]) ns = 2;
                2: if (dk) ns = 0; else if (ig) ns = 4; else if (od) ns = 3;
                3: if (dk) ns = 0; else if (cyc == mdl[k]) ns = 4;
                4: if (dk) ns = 0; else if (cyc == mdl[k]) ns = 2;
                default: ns = 0;
            endcase
            if (ns != mst[k]) begin
                mst[k] = ns;
                case (ns)
                    1: mdl[k] = cyc + AD[k];
                    3: mdl[k] = cyc + ED[k];
                    4: mdl[k] = cyc + ST[k];
                    default: mdl[k] = 0;
                endcase
            end
        end
    endtask

    // Drive one cycle of inputs, advance model, settle past the edge
    task automatic step(input bit ps, od, ig, dk);
        PassiveSignal = ps;
        OpenDoorSign = od;
        IgnitionSignalOn = ig;
        DisarmKey = dk;
        @(posedge clk);
        model_edge(ps, od, ig, dk);
        #1;
    endtask

    task automatic go_idle();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask

    task automatic go_armed();
        go_idle();
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        #12;
        tests_run++;
        if ({led0, arm0, sir0, st0} !== 6'b0) begin
            failed++;
            $display("FAIL reset_state: got %b exp 000000",
                     {led0, arm0, sir0, st0});
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        mst = '{0, 0};
        step(0, 0, 0, 0);
        tests_run++;
        if (st0 !== 3'd0) begin
            failed++;
            $display("FAIL reset_release: State=%0d exp 0", st0);
        end
    endtask

    task automatic test_reset_mid_alarm();
        go_armed();
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        tests_run++;
        if (sir0 !== 1'b1 || st0 !== 3'd4) begin
            failed++;
            $display("FAIL rst_alarm_pre: Siren=%b State=%0d exp 1/4",
                     sir0, st0);
        end
        #2;
        reset_L = 1'b0;
        #1;
        mst = '{0, 0};
        tests_run++;
        if (sir0 !== 1'b0 || arm0 !== 1'b0 || st0 !== 3'd0) begin
            failed++;
            $display("FAIL rst_alarm_async: Siren=%b Armed=%b State=%0d exp 0/0/0",
                     sir0, arm0, st0);
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            tests_run++;
            if (st0 !== 3'd0) begin
                failed++;
                $display("FAIL rst_alarm_idle: State=%0d exp 0", st0);
            end
        end
    endtask

    task automatic test_arming();
        go_idle();
        for (int i = 1; i <= 17; i++) begin
            step(1, 0, 0, 0);
            tests_run++;
            if (i <= 16) begin
                if (led0 !== 1'b1 || arm0 !== 1'b0 || st0 !== 3'd1) begin
                    failed++;
                    $display("FAIL arming_%0d: Led=%b Armed=%b State=%0d exp 1/0/1",
                             i, led0, arm0, st0);
                end
            end else begin
                if (led0 !== 1'b0 || arm0 !== 1'b1 || st0 !== 3'd2) begin
                    failed++;
                    $display("FAIL armed_%0d: Led=%b Armed=%b State=%0d exp 0/1/2",
                             i, led0, arm0, st0);
                end
            end
        end
    endtask

    task automatic test_arming_drop();
        bit seen;
        seen = 1'b0;
        go_idle();
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0);
            if (arm0 === 1'b1) seen = 1'b1;
        end
        step(0, 0, 0, 0);
        tests_run++;
        if (st0 !== 3'd0 || led0 !== 1'b0) begin
            failed++;
            $display("FAIL arm_drop: State=%0d Led=%b exp 0/0", st0, led0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (arm0 === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            failed++;
            $display("FAIL arm_drop_never: Armed rose=1 exp 0");
        end
    endtask

    task automatic test_entry_alarm();
        go_armed();
        step(0, 1, 0, 0);
        tests_run++;
        if (st0 !== 3'd3 || sir0 !== 1'b0 || arm0 !== 1'b1) begin
            failed++;
            $display("FAIL entry_enter: State=%0d Siren=%b exp 3/0", st0, sir0);
        end
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0);
            tests_run++;
            if (i < 8) begin
                if (st0 !== 3'd3 || sir0 !== 1'b0) begin
                    failed++;
                    $display("FAIL entry_%0d: State=%0d Siren=%b exp 3/0",
                             i, st0, sir0);
                end
            end else if (i < 40) begin
                if (st0 !== 3'd4 || sir0 !== 1'b1 || arm0 !== 1'b1) begin
                    failed++;
                    $display("FAIL alarm_%0d: State=%0d Siren=%b exp 4/1",
                             i, st0, sir0);
                end
            end else begin
                if (st0 !== 3'd2 || sir0 !== 1'b0 || arm0 !== 1'b1) begin
                    failed++;
                    $display("FAIL rearm: State=%0d Siren=%b Armed=%b exp 2/0/1",
                             st0, sir0, arm0);
                end
            end
        end
    endtask

    task automatic test_ignition();
        go_armed();
        step(1, 1, 1, 0);
        tests_run++;
        if (st0 !== 3'd4 || sir0 !== 1'b1) begin
            failed++;
            $display("FAIL ignition: State=%0d Siren=%b exp 4/1", st0, sir0);
        end
    endtask

    task automatic test_disarm_priority();
        bit seen;
        seen = 1'b0;
        go_armed();
        step(1, 1, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0, 0);
            if (sir0 === 1'b1) seen = 1'b1;
        end
        step(1, 0, 0, 1);
        if (sir0 === 1'b1) seen = 1'b1;
        tests_run++;
        if (st0 !== 3'd0 || seen) begin
            failed++;
            $display("FAIL disarm_entry: State=%0d sirenSeen=%b exp 0/0",
                     st0, seen);
        end
        go_armed();
        step(1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        tests_run++;
        if ({led0, arm0, sir0, st0} !== 6'b0) begin
            failed++;
            $display("FAIL disarm_alarm: got %b exp 000000",
                     {led0, arm0, sir0, st0});
        end
    endtask

    task automatic test_corner();
        logic [2:0] exp_st[5];
        bit         dr[5][4];
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
        dr = '{'{1, 0, 0, 0}, '{1, 0, 0, 0}, '{1, 1, 0, 0},
               '{1, 0, 0, 0}, '{1, 0, 0, 0}};
        go_idle();
        for (int i = 0; i < 5; i++) begin
            step(dr[i][0], dr[i][1], dr[i][2], dr[i][3]);
            tests_run++;
            if (st1 !== exp_st[i] || sir1 !== (exp_st[i] == 3'd4)) begin
                failed++;
                $display("FAIL corner_%0d: State=%0d Siren=%b exp %0d",
                         i, st1, sir1, exp_st[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit ps, od, ig, dk;
            ps = ($urandom_range(0, 7) != 0);
            od = ($urandom_range(0, 9) == 0);
            ig = ($urandom_range(0, 24) == 0);
            dk = ($urandom_range(0, 39) == 0);
            step(ps, od, ig, dk);
            tests_run++;
            if (st0 !== 3'(mst[0]) || led0 !== (mst[0] == 1) ||
                arm0 !== (mst[0] >= 2) || sir0 !== (mst[0] == 4)) begin
                failed++;
                $display("FAIL rand0_%0d: State=%0d L%b A%b S%b exp %0d",
                         n, st0, led0, arm0, sir0, mst[0]);
            end
            tests_run++;
            if (st1 !== 3'(mst[1]) || led1 !== (mst[1] == 1) ||
                arm1 !== (mst[1] >= 2) || sir1 !== (mst[1] == 4)) begin
                failed++;
                $display("FAIL rand1_%0d: State=%0d L%b A%b S%b exp %0d",
                         n, st1, led1, arm1, sir1, mst[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_arming_drop();
        test_entry_alarm();
        test_ignition();
        test_disarm_priority();
        test_reset_mid_alarm();
        test_corner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/passive_arm_ctrl.md
# passive_arm_ctrl

Sequential arming and alarm controller that sits directly downstream of the passive-security decode stage. It consumes PassiveSignal, the combinational "vehicle left secured" indication built from CarLightsOnSign, OpenDoorSign and IgnitionSignalOn. It times an arming delay, watches for door or ignition intrusion while armed, runs an entry grace period, and drives a time-limited siren. A key-fob disarm pulse overrides everything.

## Interface
- ARM_DELAY, 16: cycles spent in ARMING before the block becomes armed.
- ENTRY_DELAY, 8: grace cycles after a door opens while armed.
- SIREN_TIME, 32: cycles the siren sounds before the block re-arms.
- CNT_W, 8: counter width. Every delay must satisfy 1 <= delay <= 2^CNT_W.
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
- PassiveSignal  in  1  secured indication from the passive decode stage.
- OpenDoorSign  in  1  door-open sensor.
- IgnitionSignalOn  in  1  ignition sensor.
- DisarmKey  in  1  key-fob disarm pulse, one or more cycles wide.
- ArmingLed  out  1  high while the FSM is in ARMING.
- Armed  out  1  high in ARMED, ENTRY and ALARM.
- Siren  out  1  high in ALARM only.
- State  out  3  current state code.

## Operation
- States and codes: IDLE=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5–7 are illegal and return to IDLE on the next edge.
- One shared counter, CNT_W bits wide:
  - clears to 0 on every state change;
  - increments by 1 each cycle while the state is held;
  - never wraps, because every exit fires at delay-1.
- Transitions are evaluated every edge. DisarmKey has the highest priority in every state.
  - IDLE: PassiveSignal=1 -> ARMING.
  - ARMING: DisarmKey=1 or PassiveSignal=0 -> IDLE. Otherwise, counter == ARM_DELAY-1 -> ARMED.
  - ARMED: DisarmKey=1 -> IDLE. Otherwise IgnitionSignalOn=1 -> ALARM. Otherwise OpenDoorSign=1 -> ENTRY. Ignition wins if door and ignition rise together. PassiveSignal is ignored.
  - ENTRY: DisarmKey=1 -> IDLE. Otherwise counter == ENTRY_DELAY-1 -> ALARM. Door closing or ignition turning on does not shorten or cancel the entry delay.
  - ALARM: DisarmKey=1 -> IDLE. Otherwise counter == SIREN_TIME-1 -> ARMED (automatic re-arm).
- Outputs are Moore outputs, registered and decoded from the state register. There are no combinational input-to-output paths.

## Timing
- Reset (reset_L=0) takes effect immediately, without waiting for a clock edge:
  - State=0, counter=0, ArmingLed=0, Armed=0, Siren=0.
  - Assertion in the middle of any state, including ALARM, drops Siren at once.
  - After release, the first rising edge evaluates the IDLE rules.
- All inputs are already synchronous to clk and are sampled on the rising edge.
- Latencies (edge E is the edge that enters the named state):
  - PassiveSignal rise sampled at edge E0 -> ArmingLed=1 after E0.
  - Armed=1 after edge E0+ARM_DELAY, provided PassiveSignal stays high.
  - Door sampled at edge D -> State=ENTRY after D. Siren=1 after edge D+ENTRY_DELAY.
  - Ignition sampled while ARMED -> Siren=1 after that same edge (1-cycle latency).
  - Siren stays high for exactly SIREN_TIME cycles, then State=ARMED and Armed stays 1.
- DisarmKey sampled at any edge -> State=IDLE and all outputs 0 after that edge.
- A delay parameter of 1 means a single cycle in that state.
- Simultaneous DisarmKey and any transition condition: IDLE wins.
- Simultaneous counter expiry and PassiveSignal drop in ARMING: IDLE wins.

## Test plan
- Reset mid-ALARM: reach ALARM, then assert reset_L=0 between clock edges -> Siren, Armed and State go to 0 immediately. After release with PassiveSignal=0, the block stays IDLE.
- Arming: hold PassiveSignal=1 from edge 0 -> ArmingLed=1 for edges 1..16, Armed=1 and State=2 from edge 17. Repeat but drop PassiveSignal at edge 10 -> State=0 at edge 11, Armed never rises.
- Entry then alarm: in ARMED, pulse OpenDoorSign for 1 cycle at edge D -> State=3 at D+1, Siren=1 at D+9, Siren=0 and State=2 at D+41.
- Ignition intrusion: in ARMED, assert IgnitionSignalOn and OpenDoorSign at the same edge -> State=4 and Siren=1 on the next edge; ENTRY is never visited.
- Disarm priority: DisarmKey=1 at the same edge the ENTRY counter reaches 7 -> State=0, Siren never asserts. Also pulse DisarmKey mid-ALARM -> all outputs 0 on the next edge.
- Parameter corner: ARM_DELAY=ENTRY_DELAY=SIREN_TIME=1, CNT_W=1 -> each timed state lasts exactly 1 cycle, with no counter overflow.
